// File: rtl/mips_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mips_pkg : shared constants and types for the instruction front end  |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
package mips_pkg;

    localparam int          INSTR_W          = 32;
    localparam logic [31:0] PC_INC           = 32'd4;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } fetch_state_e;

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sync_fifo : single-clock FIFO with flush; head is zero when empty    |
// | Revision  : 1.0                                                      |
// +----------------------------------------------------------------------+
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         push_data_i,
    input  logic                     pop_i,
    input  logic                     flush_i,
    output logic [WIDTH-1:0]         head_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    rd_ptr_q;
    logic [AW-1:0]    wr_ptr_q;
    logic [CW-1:0]    count_q;
    logic             do_push;
    logic             do_pop;

    assign do_push = push_i && !flush_i && (count_q != CW'(DEPTH));
    assign do_pop  = pop_i && (count_q != '0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    // Storage needs no reset: the head is masked while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data_i;
    end

    assign head_o  = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
    assign count_o = count_q;

endmodule
`default_nettype wire

// File: rtl/if_fetch_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | if_fetch_unit : credit-based instruction fetch with redirect flush   |
// | Revision      : 1.0                                                  |
// +----------------------------------------------------------------------+
module if_fetch_unit
    import mips_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               redirect,
    input  logic [31:0]        redirect_pc,
    output logic               imem_req_valid,
    output logic [31:0]        imem_req_addr,
    input  logic               imem_req_ready,
    input  logic               imem_rsp_valid,
    input  logic [INSTR_W-1:0] imem_rsp_data,
    output logic               instr_valid,
    output logic [INSTR_W-1:0] instr,
    output logic [31:0]        instr_pc,
    input  logic               instr_ready
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [CW-1:0] discard_q, discard_d;
    fetch_state_e  state_q, state_d;

    logic [CW-1:0] outstanding;
    logic [CW-1:0] data_count;
    logic [31:0]   tag_head;
    logic          req_fire;
    logic          unused_redirect_bits;

    assign unused_redirect_bits = ^redirect_pc[1:0];

    // Credits cover in-flight requests too, so every response has a slot.
    assign imem_req_valid = !redirect &&
        ((CW+1)'(outstanding) + (CW+1)'(data_count) < (CW+1)'(DEPTH));
    assign imem_req_addr  = fetch_pc_q;
    assign req_fire       = imem_req_valid && imem_req_ready;
    assign instr_valid    = (data_count != '0);

    // The tag queue occupancy is the outstanding-request counter.
    sync_fifo #(.WIDTH(32), .DEPTH(DEPTH)) u_tag_q (
        .clk         (clk),
        .reset       (reset),
        .push_i      (req_fire),
        .push_data_i (fetch_pc_q),
        .pop_i       (imem_rsp_valid),
        .flush_i     (1'b0),
        .head_o      (tag_head),
        .count_o     (outstanding)
    );

    sync_fifo #(.WIDTH(32 + INSTR_W), .DEPTH(DEPTH)) u_data_q (
        .clk         (clk),
        .reset       (reset),
        .push_i      (imem_rsp_valid && (state_q == ST_RUN) && !redirect),
        .push_data_i ({tag_head, imem_rsp_data}),
        .pop_i       (instr_valid && instr_ready),
        .flush_i     (redirect),
        .head_o      ({instr_pc, instr}),
        .count_o     (data_count)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_pc_q <= RESET_PC;
            discard_q  <= '0;
            state_q    <= ST_RUN;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            discard_q  <= discard_d;
            state_q    <= state_d;
        end
    end

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        discard_d  = discard_q;
        state_d    = state_q;
        if (redirect) begin
            fetch_pc_d = {redirect_pc[31:2], 2'b00};
            // A response landing in the redirect cycle is already stale.
            discard_d  = outstanding - CW'(imem_rsp_valid);
        end else begin
            if (req_fire) fetch_pc_d = fetch_pc_q + PC_INC;
            if (imem_rsp_valid && (state_q == ST_FLUSH)) discard_d = discard_q - CW'(1);
        end
        state_d = (discard_d != '0) ? ST_FLUSH : ST_RUN;
    end

endmodule
`default_nettype wire

// File: tb/tb_if_fetch_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_if_fetch_unit : randomized scoreboard bench for if_fetch_unit     |
// | Revision         : 1.0                                               |
// +----------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_if_fetch_unit;

    localparam int          DEPTH = 4;
    localparam logic [31:0] RPC   = 32'h0000_0000;

    logic        clk;
    logic        reset;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_ready;

    if_fetch_unit #(.DEPTH(DEPTH), .RESET_PC(RPC)) dut (
        .clk            (clk),
        .reset          (reset),
        .redirect       (redirect),
        .redirect_pc    (redirect_pc),
        .imem_req_valid (imem_req_valid),
        .imem_req_addr  (imem_req_addr),
        .imem_req_ready (imem_req_ready),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .instr_valid    (instr_valid),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .instr_ready    (instr_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h8BAD_F00D;
    endfunction

    typedef struct {
        logic [31:0] addr;
        int          due;
    } rsp_t;

    // Memory model and stimulus state
    rsp_t        mq[$];
    logic [31:0] rq[$];
    int          cyc, last_due, n_req;
    logic [31:0] fetch_exp;
    bit          redir_prev;
    int          p_mready, p_dready, lat_lo, lat_hi, p_redir;
    int          force_at_inflight;
    bit          force_now;
    logic [31:0] forced_target;

    // Monitor / scoreboard state
    logic [31:0] exp_pc;
    logic [31:0] last_pc;
    int          n_pop = 0;
    bit          mon_redir_prev;
    bit          saw_wrap = 0;
    bit          saw_100  = 0;

    task automatic tick();
        int          lat;
        int          d;
        bit          acc;
        bit          do_redir;
        logic [31:0] tgt;
        acc = imem_req_valid && imem_req_ready;
        if (redirect)   check("no_req_in_redirect", 32'(imem_req_valid), 32'd0);
        if (redir_prev) check("addr_after_redirect", imem_req_addr, fetch_exp);
        if (acc) begin
            check("req_addr", imem_req_addr, fetch_exp);
            lat = $urandom_range(lat_hi, lat_lo);
            d   = cyc + lat;
            if (d <= last_due) d = last_due + 1;
            last_due = d;
            mq.push_back('{addr: imem_req_addr, due: d});
            n_req++;
        end
        if (imem_rsp_valid) void'(mq.pop_front());
        check("inflight_bound", 32'(mq.size() <= DEPTH), 32'd1);
        check("discard_le_outstanding", 32'(dut.discard_q <= dut.outstanding), 32'd1);
        redir_prev = redirect;
        if (redirect) fetch_exp = {redirect_pc[31:2], 2'b00};
        else if (acc) fetch_exp = fetch_exp + 32'd4;

        @(posedge clk);
        #1;
        cyc++;
        if (mq.size() > 0 && mq[0].due <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_word(mq[0].addr);
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = $urandom;
        end
        imem_req_ready = ($urandom_range(99, 0) < p_mready);
        instr_ready    = ($urandom_range(99, 0) < p_dready);
        do_redir = 1'b0;
        tgt      = 32'h0;
        if (force_now) begin
            do_redir  = 1'b1;
            force_now = 1'b0;
            tgt       = forced_target;
        end else if (force_at_inflight >= 0 && mq.size() == force_at_inflight) begin
            do_redir          = 1'b1;
            force_at_inflight = -1;
            tgt               = forced_target;
        end else if ($urandom_range(99, 0) < p_redir) begin
            do_redir = 1'b1;
            if ($urandom_range(3, 0) == 0) tgt = 32'hFFFF_FFE0 + 32'($urandom_range(31, 0));
            else                           tgt = $urandom;
        end
        redirect    = do_redir;
        redirect_pc = do_redir ? tgt : $urandom;
        if (do_redir) rq.push_back(tgt);
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        reset          = 1'b0;
        redirect       = 1'b0;
        imem_rsp_valid = 1'b0;
        mq.delete();
        cyc        = 0;
        last_due   = -1;
        n_req      = 0;
        fetch_exp  = RPC;
        redir_prev = 1'b0;
        repeat (2) @(negedge clk);
        #1 reset = 1'b1;
        #1;
    endtask

    task automatic reset_checks();
        check("rst_req_valid", 32'(imem_req_valid), 32'd1);
        check("rst_req_addr", imem_req_addr, RPC);
        check("rst_instr_valid", 32'(instr_valid), 32'd0);
        check("rst_instr", instr, 32'd0);
        check("rst_instr_pc", instr_pc, 32'd0);
        check("rst_outstanding", 32'(dut.outstanding), 32'd0);
    endtask

    // Scoreboard: each decode handshake must carry the next address of the
    // current stream; a redirect restarts the stream at the issued target.
    always @(negedge clk) begin
        logic [31:0] t;
        if (!reset) begin
            exp_pc         = RPC;
            last_pc        = 32'h1;
            mon_redir_prev = 1'b0;
            rq.delete();
        end else begin
            if (mon_redir_prev) check("instr_valid_after_redirect", 32'(instr_valid), 32'd0);
            if (instr_valid && instr_ready) begin
                check("instr_pc", instr_pc, exp_pc);
                check("instr", instr, mem_word(exp_pc));
                if (exp_pc == 32'h0 && last_pc == 32'hFFFF_FFFC) saw_wrap = 1'b1;
                if (exp_pc == 32'h0000_0100) saw_100 = 1'b1;
                last_pc = exp_pc;
                exp_pc  = exp_pc + 32'd4;
                n_pop++;
            end
            if (redirect) begin
                if (rq.size() == 0) begin
                    check("redirect_target_queue", 32'd0, 32'd1);
                end else begin
                    t      = rq.pop_front();
                    exp_pc = {t[31:2], 2'b00};
                end
            end
            mon_redir_prev = redirect;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        int s;
        int k;
        reset             = 1'b0;
        redirect          = 1'b0;
        redirect_pc       = 32'h0;
        imem_rsp_valid    = 1'b0;
        imem_rsp_data     = 32'h0;
        p_mready          = 100;
        p_dready          = 100;
        lat_lo            = 1;
        lat_hi            = 1;
        p_redir           = 0;
        force_at_inflight = -1;
        force_now         = 1'b0;
        forced_target     = 32'h0;
        imem_req_ready    = 1'b1;
        instr_ready       = 1'b1;

        // Streaming at one instruction per cycle
        do_reset();
        reset_checks();
        repeat (5) tick();
        s = n_pop;
        repeat (10) tick();
        check("throughput", 32'(n_pop - s), 32'd10);

        // Decode stalled from reset: credits cap issue at DEPTH
        p_dready    = 0;
        instr_ready = 1'b0;
        do_reset();
        reset_checks();
        repeat (10) tick();
        check("stall_req_count", 32'(n_req), 32'(DEPTH));
        check("stall_req_valid", 32'(imem_req_valid), 32'd0);
        check("stall_instr_valid", 32'(instr_valid), 32'd1);
        check("stall_head_pc", instr_pc, 32'h0);
        p_dready = 100;
        repeat (12) tick();

        // Redirect with three requests in flight at latency 3
        lat_lo = 3;
        lat_hi = 3;
        repeat (6) tick();
        forced_target     = 32'h0000_0103;
        force_at_inflight = 3;
        k = 0;
        while (force_at_inflight >= 0 && k < 50) begin
            tick();
            k++;
        end
        check("redirect_inflight_fired", 32'(force_at_inflight < 0), 32'd1);
        repeat (12) tick();
        check("saw_pc_100", 32'(saw_100), 32'd1);

        // Redirect coinciding with a response and an accepted-ready request
        lat_lo = 1;
        lat_hi = 1;
        repeat (6) tick();
        forced_target = 32'h0000_2000;
        force_now     = 1'b1;
        repeat (10) tick();

        // Address wrap at the top of the space
        forced_target = 32'hFFFF_FFF8;
        force_now     = 1'b1;
        repeat (12) tick();
        check("saw_wrap", 32'(saw_wrap), 32'd1);

        // Randomized traffic
        p_mready = 70;
        p_dready = 70;
        lat_lo   = 1;
        lat_hi   = 4;
        p_redir  = 3;
        s = n_pop;
        repeat (10000) tick();
        check("random_progress", 32'(n_pop - s > 500), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/if_fetch_unit.md
# if_fetch_unit

Instruction fetch stage sitting directly downstream of the PC logic and upstream of decode. It owns the fetch-address register, issues in-order word reads to instruction memory over a valid/ready request channel, and buffers returned instructions with their PCs in a small FIFO. Decode consumes them over a valid/ready channel. Branch/jump redirects flush the FIFO and discard in-flight responses.

## Interface
- `DEPTH`, 4: FIFO entries and maximum outstanding-plus-buffered fetches; power of two, ≥2.
- `RESET_PC`, 32'h0000_0000: fetch address after reset; bits [1:0] must be 0.
- `clk` input 1: single clock, rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `redirect` input 1: one-cycle pulse; new control-flow target valid.
- `redirect_pc` input 32: target address; bits [1:0] ignored (treated as 0).
- `imem_req_valid` output 1: read request valid.
- `imem_req_addr` output 32: word-aligned read address.
- `imem_req_ready` input 1: memory accepts request when high with valid.
- `imem_rsp_valid` input 1: response data valid; responses in request order, no backpressure.
- `imem_rsp_data` input 32: instruction word.
- `instr_valid` output 1: FIFO head valid.
- `instr` output 32: head instruction.
- `instr_pc` output 32: address of head instruction.
- `instr_ready` input 1: decode consumes head when high with valid.

## Operation
- `fetch_pc` register, resets to `RESET_PC`; drives `imem_req_addr`.
- Credit rule: `imem_req_valid` = (`outstanding` + `count`) < `DEPTH` and not `redirect`. Guarantees every response has a FIFO slot; FIFO never overflows.
- Request accepted (valid & ready): `fetch_pc` += 4, modulo 2^32 (32'hFFFF_FFFC wraps to 0); address pushed to an internal PC tag queue (depth `DEPTH`); `outstanding` +1.
- Response: `outstanding` −1; tag popped. If `discard` > 0, drop data, `discard` −1; else push {data, tag} into FIFO.
- Pop: `instr_valid` & `instr_ready` removes head.
- Redirect (highest priority): FIFO `count` → 0; `fetch_pc` ← {`redirect_pc`[31:2], 2'b00}; `discard` ← number of requests still in flight after this cycle's response is processed (response arriving in the redirect cycle is dropped too); no request issued in redirect cycle. First post-redirect request issues the next cycle.
- Pop and push in same cycle: count unchanged. Pop in redirect cycle is still a legal handshake to decode but FIFO clears regardless.
- Counters `outstanding`, `discard` sized $clog2(DEPTH)+1 bits; `discard` ≤ `outstanding` always.
- Control states: RUN (`discard` = 0) and FLUSH (`discard` > 0); FLUSH → RUN when last stale response dropped. Requests may issue in FLUSH subject to credits (credits count stale requests too).

## Timing
- Reset values: `imem_req_valid` 1 after release (asserted combinationally from reset state), `imem_req_addr` = `RESET_PC`, `instr_valid` 0, `instr`/`instr_pc` 0, all counters 0.
- Response at edge N appears on `instr`/`instr_valid` after edge N (registered FIFO write, no bypass): earliest consume one cycle after response.
- Redirect at cycle R: `instr_valid` 0 from R+1; `imem_req_addr` = target at R+1.
- Memory with 1-cycle response latency and `instr_ready` tied high sustains one instruction per cycle.
- Reset mid-operation: all state cleared immediately; responses for pre-reset requests are memory's responsibility to suppress.

## Structure
- Shared package `mips_pkg`: `RESET_PC` default, `INSTR_W = 32`, `PC_INC = 4`.
- One sub-module `sync_fifo` (parameter WIDTH, DEPTH; push, pop, flush, count), instantiated twice: data FIFO (WIDTH 64, {pc, instr}) and PC tag queue (WIDTH 32, flushed never—tags of stale requests popped normally).

## Test plan
- Reset release, memory ready, 1-cycle latency, `instr_ready`=1 → instr_pc 0x0, 0x4, 0x8, … one per cycle from cycle 2.
- `instr_ready`=0 for 10 cycles → exactly 4 requests issued, `imem_req_valid` low, FIFO holds PCs 0x0–0xC; release → drained in order, fetching resumes at 0x10.
- Memory latency 3 cycles, redirect to 0x0000_0103 with 3 in flight → 3 stale responses dropped, next `instr_pc` = 0x0000_0100.
- Redirect in same cycle as a response and a request handshake → both dropped, no request at old address accepted, no stale instruction reaches decode.
- `RESET_PC` = 32'hFFFF_FFF8 → instr_pc sequence FFFF_FFF8, FFFF_FFFC, 0000_0000.
- Random `imem_req_ready`, `instr_ready`, latency 1–4, random redirects, 10k cycles → scoreboard: output PCs contiguous between redirects, never overflow, `discard` ≤ `outstanding`.
